// File: rtl/dizy_key_loader.sv
// dizy_key_loader
//   Key-side front end for the DIZY key extension stage. Collects a SIZE_KEY-bit
//   key from WORD_W-bit words (most significant word first) over a valid/ready
//   bus, holds it stable, and sequences the round counter while a block runs.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   key_word_in     key word, MS word first
//   key_word_valid  key_word_in is valid
//   key_word_ready  word accepted when valid & ready at the clock edge
//   start           begin a block run with the held key
//   rnd_adv         datapath finished the current round
//   key_out         held key (key extension input)
//   key_valid       key_out holds a complete key
//   rnd_cnt         current round index, 0 outside a run
//   busy            high while a block run is in progress
//   done            one-cycle pulse after the final round
module dizy_key_loader #(
    parameter int SIZE_KEY = 80,
    parameter int WORD_W   = 16,
    parameter int NUM_RND  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   key_word_in,
    input  logic                key_word_valid,
    output logic                key_word_ready,
    input  logic                start,
    input  logic                rnd_adv,
    output logic [SIZE_KEY-1:0] key_out,
    output logic                key_valid,
    output logic [2:0]          rnd_cnt,
    output logic                busy,
    output logic                done
);

    localparam int NW  = SIZE_KEY / WORD_W;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [WCW-1:0]      word_cnt_r;
    logic [WCW-1:0]      word_cnt_s;
    logic [SIZE_KEY-1:0] key_out_s;
    logic                key_valid_s;
    logic [2:0]          rnd_cnt_s;
    logic                busy_s;
    logic                done_s;
    logic                accept_s;

    // A start in READY takes priority, so the word offered in that cycle is refused.
    assign key_word_ready = (state_r != RUN) && !((state_r == READY) && start);
    assign accept_s       = key_word_valid && key_word_ready;

    // Next-state and next-output logic for the load/run sequencer.
    always_comb begin
        state_s     = state_r;
        word_cnt_s  = word_cnt_r;
        key_out_s   = key_out;
        key_valid_s = key_valid;
        rnd_cnt_s   = rnd_cnt;
        busy_s      = busy;
        done_s      = 1'b0;
        case (state_r)
            EMPTY, LOAD, READY: begin
                if ((state_r == READY) && start) begin
                    state_s   = RUN;
                    busy_s    = 1'b1;
                    rnd_cnt_s = 3'd0;
                end else if (accept_s) begin
                    // Shift the new word in at the bottom; the concat truncates the oldest bits.
                    key_out_s = SIZE_KEY'({key_out, key_word_in});
                    if (word_cnt_r == WCW'(NW - 1)) begin
                        word_cnt_s  = '0;
                        key_valid_s = 1'b1;
                        state_s     = READY;
                    end else begin
                        word_cnt_s  = word_cnt_r + WCW'(1);
                        key_valid_s = 1'b0;
                        state_s     = LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (rnd_adv) begin
                    if (rnd_cnt == 3'(NUM_RND - 1)) begin
                        rnd_cnt_s = 3'd0;
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                        state_s   = READY;
                    end else begin
                        rnd_cnt_s = rnd_cnt + 3'd1;
                    end
                end else begin
                    rnd_cnt_s = rnd_cnt;
                end
            end
            default: begin
                state_s     = EMPTY;
                word_cnt_s  = '0;
                key_out_s   = '0;
                key_valid_s = 1'b0;
                rnd_cnt_s   = 3'd0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, including a partial run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= EMPTY;
            word_cnt_r <= '0;
            key_out    <= '0;
            key_valid  <= 1'b0;
            rnd_cnt    <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_cnt_r <= word_cnt_s;
            key_out    <= key_out_s;
            key_valid  <= key_valid_s;
            rnd_cnt    <= rnd_cnt_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

endmodule
